// File: rtl/db_port_arb_pkg.sv
// Shared memory-subsystem constants: default bank geometry, requester indices
// and the round-robin priority encoding.
package kf_mem_pkg;

    localparam int W     = 24;
    localparam int DEPTH = 40;
    localparam int ADDRW = 6;

    localparam int REQ_HOST = 0;
    localparam int REQ_DP   = 1;

    // Which requester wins when both ask in the same cycle.
    typedef enum logic {
        PRI_HOST = 1'b0,
        PRI_DP   = 1'b1
    } pri_e;

endpackage

// File: rtl/db_port_arb_if.sv
// Requester-side bus of the data-bank port arbiter: write and read-pair
// handshakes plus the read response.
interface db_port_arb_if #(
    parameter int W     = 24,
    parameter int ADDRW = 6
) ();

    logic [1:0]         wr_valid;
    logic [1:0]         wr_ready;
    logic [2*ADDRW-1:0] wr_addr;
    logic [2*W-1:0]     wr_data;
    logic [1:0]         rd_valid;
    logic [1:0]         rd_ready;
    logic [4*ADDRW-1:0] rd_addr;
    logic [1:0]         rsp_valid;
    logic [2*W-1:0]     rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/db_port_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the current priority,
// priority flips to the other requester after every grant.
module rr_arb2
    import kf_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    pri_e pri, pri_nxt;

    // Priority register; reset favours the host loader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= PRI_HOST;
        end else begin
            pri <= pri_nxt;
        end
    end

    // Grant selection and next priority; no grant at all while in reset.
    always_comb begin
        gnt     = '0;
        pri_nxt = pri;
        if (rst_n) begin
            if (req[REQ_HOST] && (!req[REQ_DP] || pri == PRI_HOST)) begin
                gnt[REQ_HOST] = 1'b1;
            end else if (req[REQ_DP]) begin
                gnt[REQ_DP] = 1'b1;
            end
        end
        if (gnt[REQ_HOST]) begin
            pri_nxt = PRI_DP;
        end else if (gnt[REQ_DP]) begin
            pri_nxt = PRI_HOST;
        end
    end

endmodule

// File: rtl/db_port_arb.sv
// Data-bank port arbiter: one write port and one dual-address read port shared
// by the host loader and the datapath, with range checking against DEPTH.
module db_port_arb
    import kf_mem_pkg::*;
#(
    parameter int W     = kf_mem_pkg::W,
    parameter int DEPTH = kf_mem_pkg::DEPTH,
    parameter int ADDRW = kf_mem_pkg::ADDRW
) (
    input  logic             clk,
    input  logic             rst_n,
    db_port_arb_if.slave     bus,
    output logic             err_addr,
    input  logic             clr_err,
    output logic             db_we,
    output logic [ADDRW-1:0] db_waddr,
    output logic [W-1:0]     db_wdata,
    output logic [ADDRW-1:0] db_raddr_a,
    output logic [ADDRW-1:0] db_raddr_b,
    input  logic [W-1:0]     db_rdata_a,
    input  logic [W-1:0]     db_rdata_b
);

    // One extra bit so DEPTH == 2**ADDRW still compares correctly.
    localparam logic [ADDRW:0] LIMIT = (ADDRW + 1)'(DEPTH);

    logic [1:0]       wr_gnt, rd_gnt;
    logic             wr_xfer, rd_xfer;
    logic [ADDRW-1:0] w_addr, ra_addr, rb_addr;
    logic [W-1:0]     w_data;
    logic             w_ok, ra_ok, rb_ok;
    logic             err_set;
    logic [2*W-1:0]   rsp_next;

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.wr_valid),
        .gnt   (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.rd_valid),
        .gnt   (rd_gnt)
    );

    assign bus.wr_ready = wr_gnt;
    assign bus.rd_ready = rd_gnt;
    assign wr_xfer      = |wr_gnt;
    assign rd_xfer      = |rd_gnt;

    // Route the granted requester's fields onto the bank ports and range-check them.
    always_comb begin
        w_addr  = wr_gnt[REQ_DP] ? bus.wr_addr[2*ADDRW-1:ADDRW] : bus.wr_addr[ADDRW-1:0];
        w_data  = wr_gnt[REQ_DP] ? bus.wr_data[2*W-1:W]         : bus.wr_data[W-1:0];
        ra_addr = rd_gnt[REQ_DP] ? bus.rd_addr[3*ADDRW-1:2*ADDRW] : bus.rd_addr[ADDRW-1:0];
        rb_addr = rd_gnt[REQ_DP] ? bus.rd_addr[4*ADDRW-1:3*ADDRW] : bus.rd_addr[2*ADDRW-1:ADDRW];
        if (!wr_xfer) begin
            w_addr = '0;
            w_data = '0;
        end
        if (!rd_xfer) begin
            ra_addr = '0;
            rb_addr = '0;
        end
        w_ok  = ({1'b0, w_addr}  < LIMIT);
        ra_ok = ({1'b0, ra_addr} < LIMIT);
        rb_ok = ({1'b0, rb_addr} < LIMIT);

        db_we      = wr_xfer && w_ok;
        db_waddr   = w_addr;
        db_wdata   = w_data;
        db_raddr_a = ra_addr;
        db_raddr_b = rb_addr;

        err_set  = (wr_xfer && !w_ok) || (rd_xfer && (!ra_ok || !rb_ok));
        rsp_next = {rb_ok ? db_rdata_b : '0, ra_ok ? db_rdata_a : '0};
    end

    // Read response register: one-cycle strobe, data held between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= rd_gnt;
            if (rd_xfer) begin
                bus.rsp_data <= rsp_next;
            end
        end
    end

    // Sticky out-of-range flag; a new error takes precedence over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= 1'b0;
        end else if (err_set) begin
            err_addr <= 1'b1;
        end else if (clr_err) begin
            err_addr <= 1'b0;
        end
    end

endmodule

// File: doc/db_port_arb.md
DB_PORT_ARB -- requirements
Module: db_port_arb

Interface
REQ-001 The block SHALL have parameter W, default 24, meaning data word width.
REQ-002 The block SHALL have parameter DEPTH, default 40, meaning number of valid data-bank locations.
REQ-003 The block SHALL have parameter ADDRW, default 6, meaning bank address width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  2  write request, bit i = requester i (0 = host loader, 1 = datapath).
REQ-008 wr_ready  output  2  write grant per requester.
REQ-009 wr_addr  input  2*ADDRW  write address per requester, requester i in slice i.
REQ-010 wr_data  input  2*W  write data per requester.
REQ-011 rd_valid  input  2  read-pair request per requester.
REQ-012 rd_ready  output  2  read grant per requester.
REQ-013 rd_addr  input  4*ADDRW  per requester {addr_b, addr_a}.
REQ-014 rsp_valid  output  2  one-hot read response strobe.
REQ-015 rsp_data  output  2*W  response {data_b, data_a}.
REQ-016 err_addr  output  1  sticky out-of-range flag; clr_err  input  1  clears it.
REQ-017 db_we, db_waddr (ADDRW), db_wdata (W), db_raddr_a, db_raddr_b (ADDRW)  outputs  drive the data-bank ports.
REQ-018 db_rdata_a, db_rdata_b  input  W  asynchronous bank read data.

Function
REQ-019 Write port: at most one wr_ready bit SHALL be high per cycle, granted round-robin among requesters with wr_valid high; with one requester valid, it SHALL be granted the same cycle.
REQ-020 wr_ready SHALL depend combinationally on wr_valid; requesters hold valid, address and data stable until ready, and valid does not depend on ready.
REQ-021 After a write transfer (valid and ready) by requester i, write priority SHALL move to the other requester; with no transfer, priority SHALL hold.
REQ-022 db_we SHALL equal transfer AND granted wr_addr < DEPTH; db_waddr/db_wdata SHALL carry the granted requester's values, else zero.
REQ-023 A write with address >= DEPTH SHALL still complete (ready high), SHALL NOT assert db_we, and SHALL set err_addr on the next edge.
REQ-024 Read port: an independent round-robin pointer SHALL grant at most one rd_ready bit per cycle, driving db_raddr_a/b from that requester, else zero.
REQ-025 On a read transfer, db_rdata_a/b SHALL be registered into rsp_data and rsp_valid[i] SHALL be high for exactly the following cycle (latency 1).
REQ-026 With no read transfer, rsp_valid SHALL go to 0 next cycle and rsp_data SHALL hold.
REQ-027 A read lane with address >= DEPTH SHALL return 0 in that lane and set err_addr; the other lane returns normally.
REQ-028 A write and a read to the same address in the same cycle SHALL return the new write data, via bank write-through; the arbiter SHALL add no extra forwarding.
REQ-029 Write and read arbitration SHALL be independent; one requester may hold both grants in one cycle.
REQ-030 clr_err SHALL clear err_addr on the next edge; a simultaneous new error SHALL win (flag stays 1).

Reset
REQ-031 While rst_n is low: both round-robin pointers SHALL favour requester 0, rsp_valid=0, rsp_data=0, err_addr=0.
REQ-032 While rst_n is low: wr_ready, rd_ready and db_we SHALL be forced to 0, regardless of wr_valid/rd_valid.
REQ-033 Reset asserted mid-operation SHALL drop any in-flight response; the first edge after release SHALL behave as post-reset.

Structure
REQ-034 Shared package kf_mem_pkg SHALL hold W, DEPTH, ADDRW and requester index constants REQ_HOST=0, REQ_DP=1.
REQ-035 A sub-module rr_arb2 (2-way round-robin grant plus pointer) SHALL be instantiated twice, once for the write port and once for the read port.

Verification
REQ-036 Both wr_valid high for 4 cycles, addr 0..3 -> grants alternate 0,1,0,1; bank holds the written patterns.
REQ-037 Host writes 0xDEADBE to addr 3 while datapath reads {2,3} same cycle -> next cycle rsp_valid=2'b10, rsp_data_a=0xDEADBE.
REQ-038 Datapath write to addr 45 -> wr_ready high, db_we low, err_addr=1 next cycle; clr_err and new error in the same cycle -> err_addr stays 1.
REQ-039 Both rd_valid high continuously -> rsp_valid alternates 01,10 with 1-cycle latency; each requester's data matches its addresses.
REQ-040 rst_n low during a read grant -> rsp_valid=0 and rsp_data=0 immediately, readies 0; after release, requester 0 wins the first contention.
